uart_rx_cfg: RTL



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sampler.sv | 65 ++++++
 rtl/uart_rx_cfg.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } rx_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // Centre phase of a bit period.
  function automatic int unsigned mid_phase(input int unsigned cpb);
    return (cpb - 1) / 2;
  endfunction

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Synchroniser, bit-phase counter and 3-sample majority vote.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  input  logic clear_i,
  output logic rx_s_o,
  output logic bit_value_o,
  output logic bit_strobe_o,
  output logic bit_end_o
);

  localparam int unsigned PW  = cnt_width(CLKS_PER_BIT);
  localparam int unsigned MID = mid_phase(CLKS_PER_BIT);

  localparam logic [PW-1:0] PH_EARLY = PW'(MID - 1);
  localparam logic [PW-1:0] PH_MID   = PW'(MID);
  localparam logic [PW-1:0] PH_LATE  = PW'(MID + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync_q;
  logic [PW-1:0] phase_q, phase_d;
  logic [1:0]    samp_q, samp_d;
  logic          rx_s;

  assign rx_s = sync_q[1];

  // Two-flop synchroniser on the raw line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '1;
    else         sync_q <= {sync_q[0], rx_i};
  end

  // Phase counter and early/mid sample capture next-state.
  always_comb begin
    phase_d = phase_q;
    samp_d  = samp_q;
    if (clear_i || phase_q == PH_LAST) phase_d = '0;
    else                               phase_d = phase_q + PW'(1);
    if (phase_q == PH_EARLY) samp_d[0] = rx_s;
    if (phase_q == PH_MID)   samp_d[1] = rx_s;
  end

  // Phase and sample registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
      samp_q  <= '1;
    end else begin
      phase_q <= phase_d;
      samp_q  <= samp_d;
    end
  end

  // Third sample is the live synchronised value at the late phase.
  assign bit_value_o  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign bit_strobe_o = (phase_q == PH_LATE);
  assign bit_end_o    = (phase_q == PH_LAST);
  assign rx_s_o       = rx_s;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: frame FSM, checks and valid/ready holding register.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Rx_Serial,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Rx_Valid,
  input  logic                 i_Rx_Ready,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Overrun,
  output logic                 o_Busy
);

  localparam int unsigned BW = cnt_width(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  rx_state_e state_q, state_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, nz_q, nz_d;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d, pflag_q, pflag_d, fflag_q, fflag_d;
  logic                 brk_q, brk_d, ovr_q, ovr_d;

  logic rx_s, bit_value, bit_strobe, bit_end, clear;
  logic complete, frame_ferr, frame_brk, par_exp;

  uart_rx_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
    .clk_i        (i_Clock),
    .rst_ni       (i_Rst_n),
    .rx_i         (i_Rx_Serial),
    .clear_i      (clear),
    .rx_s_o       (rx_s),
    .bit_value_o  (bit_value),
    .bit_strobe_o (bit_strobe),
    .bit_end_o    (bit_end)
  );

  assign par_exp = (^shift_q) ^ (PARITY == PARITY_ODD);

  // Frame FSM: next state, shift register and per-frame error tracking.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    nz_d       = nz_q;
    clear      = 1'b0;
    complete   = 1'b0;
    frame_ferr = ferr_q | ~bit_value;
    frame_brk  = ~(nz_q | bit_value);
    unique case (state_q)
      ST_IDLE: begin
        clear = 1'b1;
        if (!rx_s) begin
          state_d    = ST_START;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          nz_d       = 1'b0;
        end
      end
      ST_START: begin
        if (bit_strobe && bit_value) state_d = ST_IDLE;
        else if (bit_end)            state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_strobe) begin
          shift_d = {bit_value, shift_q[DATA_BITS-1:1]};
          nz_d    = nz_q | bit_value;
        end
        if (bit_end) begin
          if (bit_idx_q == LAST_BIT) state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          else                       bit_idx_d = bit_idx_q + BW'(1);
        end
      end
      ST_PARITY: begin
        if (bit_strobe) begin
          nz_d = nz_q | bit_value;
          if (bit_value != par_exp) perr_d = 1'b1;
        end
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_strobe) begin
          nz_d   = nz_q | bit_value;
          ferr_d = frame_ferr;
          // Finish at the decision point so the next start edge is caught promptly.
          if (stop_idx_q == LAST_STOP) begin
            complete = 1'b1;
            state_d  = frame_brk ? ST_BREAK_WAIT : ST_IDLE;
          end
        end
        if (bit_end) stop_idx_d = ~stop_idx_q;
      end
      ST_BREAK_WAIT: begin
        clear = 1'b1;
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding register: load on completion when empty or being drained, else overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    pflag_d = pflag_q;
    fflag_d = fflag_q;
    brk_d   = brk_q;
    ovr_d   = 1'b0;
    if (valid_q && i_Rx_Ready) valid_d = 1'b0;
    if (complete) begin
      if (!valid_q || i_Rx_Ready) begin
        data_d  = shift_q;
        pflag_d = perr_q;
        fflag_d = frame_ferr;
        brk_d   = frame_brk;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= ST_IDLE;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      nz_q       <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      pflag_q    <= 1'b0;
      fflag_q    <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      nz_q       <= nz_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      pflag_q    <= pflag_d;
      fflag_q    <= fflag_d;
      brk_q      <= brk_d;
      ovr_q      <= ovr_d;
    end
  end

  assign o_Rx_Data    = data_q;
  assign o_Rx_Valid   = valid_q;
  assign o_Parity_Err = pflag_q;
  assign o_Frame_Err  = fflag_q;
  assign o_Break      = brk_q;
  assign o_Overrun    = ovr_q;
  assign o_Busy       = (state_q != ST_IDLE);

endmodule
